// File: rtl/exe_hazard_fwd_ctrl_if.sv
// ID-stage request and EXE hazard/forwarding control bundle for exe_hazard_fwd_ctrl.
interface exe_hazard_fwd_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_src1;
    logic [REG_AW-1:0] id_src2;
    logic              id_use_src2;
    logic [REG_AW-1:0] id_dest;
    logic              id_wb_en;
    logic              id_mem_read;
    logic              br_taken;
    logic              freeze;
    logic              flush;
    logic              exe_bubble;
    logic [1:0]        src1_mux;
    logic [1:0]        src2_mux;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output id_valid, id_src1, id_src2, id_use_src2, id_dest, id_wb_en, id_mem_read, br_taken,
        input  freeze, flush, exe_bubble, src1_mux, src2_mux, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_use_src2, id_dest, id_wb_en, id_mem_read, br_taken,
        output freeze, flush, exe_bubble, src1_mux, src2_mux, stall_count, flush_count
    );
endinterface

// File: rtl/exe_hazard_fwd_ctrl.sv
// EXE-stage hazard detection, pipeline freeze/flush and ALU operand-forwarding select control.
// Build option EXE_FORWARD_EN: forward from MEM/WB; when undefined, every dependency stalls until writeback.
module exe_hazard_fwd_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    exe_hazard_fwd_ctrl_if.slave bus
);
    localparam int unsigned SEL_W = 2;
    localparam logic [SEL_W-1:0] SEL_ID  = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(2);

    logic              ex_valid, ex_wb_en, ex_mem_read;
    logic [REG_AW-1:0] ex_dest;
    logic              mem_valid, mem_wb_en;
    logic [REG_AW-1:0] mem_dest;
    logic              wb_valid, wb_wb_en;
    logic [REG_AW-1:0] wb_dest;

    logic ex_p1, ex_p2, mem_p1, mem_p2, wb_p1, wb_p2;
    logic hazard, freeze_c, advance;
    logic [CNT_W-1:0] stall_q, flush_q;

    function automatic logic produces(input logic v, input logic wb,
                                      input logic [REG_AW-1:0] d, input logic [REG_AW-1:0] r);
        return v && wb && (d == r) && (r != '0);
    endfunction

    // Producer matches against the ID sources, then hazard and stall decode
    always_comb begin
        ex_p1  = produces(ex_valid,  ex_wb_en,  ex_dest,  bus.id_src1);
        ex_p2  = bus.id_use_src2 && produces(ex_valid,  ex_wb_en,  ex_dest,  bus.id_src2);
        mem_p1 = produces(mem_valid, mem_wb_en, mem_dest, bus.id_src1);
        mem_p2 = bus.id_use_src2 && produces(mem_valid, mem_wb_en, mem_dest, bus.id_src2);
        wb_p1  = produces(wb_valid,  wb_wb_en,  wb_dest,  bus.id_src1);
        wb_p2  = bus.id_use_src2 && produces(wb_valid,  wb_wb_en,  wb_dest,  bus.id_src2);
`ifdef EXE_FORWARD_EN
        hazard = bus.id_valid && ex_mem_read && (ex_p1 || ex_p2);
`else
        hazard = bus.id_valid && (ex_p1 || ex_p2 || mem_p1 || mem_p2 || wb_p1 || wb_p2);
`endif
        freeze_c = hazard && !bus.br_taken;
        advance  = bus.id_valid && !freeze_c && !bus.br_taken;
    end

    assign bus.freeze      = freeze_c;
    assign bus.flush       = bus.br_taken;
    assign bus.exe_bubble  = hazard || bus.br_taken;
    assign bus.stall_count = stall_q;
    assign bus.flush_count = flush_q;

    // EX/MEM/WB destination scoreboard; a non-advancing edge leaves a bubble in EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_wb_en    <= 1'b0;
            ex_mem_read <= 1'b0;
            ex_dest     <= '0;
            mem_valid   <= 1'b0;
            mem_wb_en   <= 1'b0;
            mem_dest    <= '0;
            wb_valid    <= 1'b0;
            wb_wb_en    <= 1'b0;
            wb_dest     <= '0;
        end else begin
            wb_valid  <= mem_valid;
            wb_wb_en  <= mem_wb_en;
            wb_dest   <= mem_dest;
            mem_valid <= ex_valid;
            mem_wb_en <= ex_wb_en;
            mem_dest  <= ex_dest;
            ex_valid  <= advance;
            if (advance) begin
                ex_wb_en    <= bus.id_wb_en;
                ex_mem_read <= bus.id_mem_read;
                ex_dest     <= bus.id_dest;
            end
        end
    end

`ifdef EXE_FORWARD_EN
    logic [SEL_W-1:0] src1_q, src2_q;
    logic             unused_wb_slot;
    assign unused_wb_slot = wb_p1 ^ wb_p2;

    // Newest producer wins; selects travel with the instruction entering EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src1_q <= SEL_ID;
            src2_q <= SEL_ID;
        end else if (advance) begin
            src1_q <= ex_p1 ? SEL_MEM : (mem_p1 ? SEL_WB : SEL_ID);
            src2_q <= ex_p2 ? SEL_MEM : (mem_p2 ? SEL_WB : SEL_ID);
        end else begin
            src1_q <= SEL_ID;
            src2_q <= SEL_ID;
        end
    end

    assign bus.src1_mux = src1_q;
    assign bus.src2_mux = src2_q;
`else
    logic unused_fwd;
    assign unused_fwd   = ex_mem_read ^ bus.id_mem_read ^ (^SEL_MEM) ^ (^SEL_WB);
    assign bus.src1_mux = SEL_ID;
    assign bus.src2_mux = SEL_ID;
`endif

    // Saturating stall/flush event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (freeze_c && !(&stall_q))
                stall_q <= stall_q + CNT_W'(1);
            if (bus.br_taken && !(&flush_q))
                flush_q <= flush_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_exe_hazard_fwd_ctrl.sv
// Self-checking bench for exe_hazard_fwd_ctrl; expectations follow EXE_FORWARD_EN when defined.
module tb_exe_hazard_fwd_ctrl;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
`ifdef EXE_FORWARD_EN
    localparam int unsigned STALL_PER_DEP = 1;
`else
    localparam int unsigned STALL_PER_DEP = 3;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    exe_hazard_fwd_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    exe_hazard_fwd_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        bit vl; int s1; int s2; bit u2; int d; bit wb; bit ld; bit br;
        bit fz; bit bb; int m1; int m2;
    } vec_t;

    typedef struct { int idx; int m1; int m2; } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    task automatic chk(input string nm, input int idx, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s [%0d] got %0d expected %0d", nm, idx, act, exp_v);
        end
    endtask

    task automatic add(input bit vl, input int s1, input int s2, input bit u2, input int d,
                       input bit wb, input bit ld, input bit br, input bit fz, input bit bb,
                       input int m1, input int m2);
        vec_t v;
        v.vl = vl; v.s1 = s1; v.s2 = s2; v.u2 = u2; v.d = d; v.wb = wb; v.ld = ld; v.br = br;
        v.fz = fz; v.bb = bb; v.m1 = m1; v.m2 = m2;
        tbl.push_back(v);
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drive(input bit vl, input int s1, input int s2, input bit u2, input int d,
                         input bit wb, input bit ld, input bit br);
        bus.id_valid    = vl;
        bus.id_src1     = REG_AW'(s1);
        bus.id_src2     = REG_AW'(s2);
        bus.id_use_src2 = u2;
        bus.id_dest     = REG_AW'(d);
        bus.id_wb_en    = wb;
        bus.id_mem_read = ld;
        bus.br_taken    = br;
    endtask

    task automatic build_table();
        drain();
        // ALU -> ALU dependency on r3
        add(1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0);
`ifdef EXE_FORWARD_EN
        add(1, 3, 1, 1, 4, 1, 0, 0, 0, 0, 1, 0);
`else
        for (int k = 0; k < 3; k++) add(1, 3, 1, 1, 4, 1, 0, 0, 1, 1, 0, 0);
        add(1, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0);
`endif
        drain();
        // load-use on r5
        add(1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
`ifdef EXE_FORWARD_EN
        add(1, 5, 7, 1, 6, 1, 0, 0, 1, 1, 0, 0);
        add(1, 5, 7, 1, 6, 1, 0, 0, 0, 0, 2, 0);
`else
        for (int k = 0; k < 3; k++) add(1, 5, 7, 1, 6, 1, 0, 0, 1, 1, 0, 0);
        add(1, 5, 7, 1, 6, 1, 0, 0, 0, 0, 0, 0);
`endif
        drain();
        // r4 in MEM read on src2 as an immediate slot
        add(1, 1, 1, 0, 4, 1, 0, 0, 0, 0, 0, 0);
        add(1, 10, 11, 1, 9, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 4, 0, 8, 1, 0, 0, 0, 0, 0, 0);
        drain();
        // r4 in MEM read on src2 from the register file
        add(1, 1, 1, 0, 4, 1, 0, 0, 0, 0, 0, 0);
        add(1, 10, 11, 1, 9, 1, 0, 0, 0, 0, 0, 0);
`ifdef EXE_FORWARD_EN
        add(1, 1, 4, 1, 8, 1, 0, 0, 0, 0, 0, 2);
`else
        for (int k = 0; k < 2; k++) add(1, 1, 4, 1, 8, 1, 0, 0, 1, 1, 0, 0);
        add(1, 1, 4, 1, 8, 1, 0, 0, 0, 0, 0, 0);
`endif
        drain();
        // r0 destination is never a hazard source
        add(1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0);
        drain();
        // taken branch coincident with load-use
        add(1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
        add(1, 5, 7, 1, 6, 1, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drain();
        // invalid ID instruction never stalls
        add(1, 1, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0);
        add(0, 3, 3, 1, 6, 1, 0, 0, 0, 0, 0, 0);
        drain();
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        drain();
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        #3;
        chk("rst_freeze", -1, int'(bus.freeze), 0);
        chk("rst_flush", -1, int'(bus.flush), 1);
        chk("rst_bubble", -1, int'(bus.exe_bubble), 1);
        chk("rst_src1", -1, int'(bus.src1_mux), 0);
        chk("rst_src2", -1, int'(bus.src2_mux), 0);
        chk("rst_stall_cnt", -1, int'(bus.stall_count), 0);
        chk("rst_flush_cnt", -1, int'(bus.flush_count), 0);
        bus.br_taken = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        build_table();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].vl, tbl[i].s1, tbl[i].s2, tbl[i].u2, tbl[i].d, tbl[i].wb, tbl[i].ld, tbl[i].br);
            e.idx = i; e.m1 = tbl[i].m1; e.m2 = tbl[i].m2;
            sb.push_back(e);
            exp_stall += int'(tbl[i].fz);
            exp_flush += int'(tbl[i].br);
            #3;
            chk("freeze", i, int'(bus.freeze), int'(tbl[i].fz));
            chk("flush", i, int'(bus.flush), int'(tbl[i].br));
            chk("exe_bubble", i, int'(bus.exe_bubble), int'(tbl[i].bb));
            @(posedge clk); #1;
            e = sb.pop_front();
            chk("src1_mux", e.idx, int'(bus.src1_mux), e.m1);
            chk("src2_mux", e.idx, int'(bus.src2_mux), e.m2);
        end
        chk("stall_count", -2, int'(bus.stall_count), exp_stall);
        chk("flush_count", -2, int'(bus.flush_count), exp_flush);

        // reset asserted in the middle of a load-use stall
        drive(1, 0, 0, 0, 5, 1, 1, 0);
        @(posedge clk); #1;
        drive(1, 5, 7, 1, 6, 1, 0, 0);
        #3;
        chk("pre_rst_freeze", -3, int'(bus.freeze), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_freeze", -3, int'(bus.freeze), 0);
        chk("mid_rst_bubble", -3, int'(bus.exe_bubble), 0);
        chk("mid_rst_src1", -3, int'(bus.src1_mux), 0);
        chk("mid_rst_src2", -3, int'(bus.src2_mux), 0);
        chk("mid_rst_stall_cnt", -3, int'(bus.stall_count), 0);
        chk("mid_rst_flush_cnt", -3, int'(bus.flush_count), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // branch beats load-use: flush counted, stall not
        drive(1, 0, 0, 0, 5, 1, 1, 0);
        @(posedge clk); #1;
        drive(1, 5, 7, 1, 6, 1, 0, 1);
        #3;
        chk("br_freeze", -4, int'(bus.freeze), 0);
        chk("br_flush", -4, int'(bus.flush), 1);
        chk("br_bubble", -4, int'(bus.exe_bubble), 1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_stall_cnt", -4, int'(bus.stall_count), 0);
        chk("br_flush_cnt", -4, int'(bus.flush_count), 1);

        // stall counter saturation: back-to-back loads of r1 reading r1
        rst_n = 1'b0;
        drive(1, 1, 0, 0, 1, 1, 1, 0);
        #1;
        rst_n = 1'b1;
        repeat ((CNT_MAX / STALL_PER_DEP - 1) * (STALL_PER_DEP + 1)) @(posedge clk);
        #1;
        chk("sat_stall_pre", -5, int'(bus.stall_count), int'(CNT_MAX - STALL_PER_DEP));
        repeat (STALL_PER_DEP + 1) @(posedge clk);
        #1;
        chk("sat_stall_full", -5, int'(bus.stall_count), int'(CNT_MAX));
        repeat (STALL_PER_DEP + 1) @(posedge clk);
        #1;
        chk("sat_stall_hold", -5, int'(bus.stall_count), int'(CNT_MAX));

        // flush counter saturation
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (CNT_MAX + 4) @(posedge clk);
        #1;
        chk("sat_flush_hold", -6, int'(bus.flush_count), int'(CNT_MAX));
        chk("sat_flush_stall", -6, int'(bus.stall_count), int'(CNT_MAX));
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
